trap_controller: RTL and testbench
==================================

Name: trap_controller

Overview:
- Machine-mode trap sequencer for the RV32I core.
- On ECALL, EBREAK or misaligned-access exceptions it writes mepc and mcause through a dedicated CSR port, then reads mtvec and redirects the PC.
- MRET returns to mepc+4 and FENCE.I requests an instruction-cache clean, each in a single cycle.
- Sits between the decode/exception logic (trap_status) and the CSR file, and feeds the PC mux.

Parameters:
- None. CSR addresses are fixed: MTVEC=12'h305, MEPC=12'h341, MCAUSE=12'h342.

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  reset; asynchronous, active-high.
- pc  in  32  PC of the trapping instruction.
- trap_status  in  3  trap request code; 0=NONE, 1=ECALL, 2=EBREAK, 3=MISALIGNED, 4=FENCEI, 5=MRET, 6-7 treated as NONE.
- csr_read_data  in  32  combinational read data of the CSR at csr_trap_address.
- trap_target  out  32  redirect PC; valid when trap_done=1.
- ic_clean  out  1  instruction-cache clean request (FENCE.I).
- debug_mode  out  1  registered debug flag.
- trap_done  out  1  trap handling complete this cycle; pipeline may redirect or resume.
- csr_write_enable  out  1  CSR write strobe.
- csr_trap_address  out  12  CSR address for the read or write.
- csr_trap_write_data  out  32  CSR write data.

Behaviour:
- Registered state trap_handle_state: IDLE, WRITE_MEPC, WRITE_MCAUSE, READ_MTVEC. All other outputs are combinational from state, the latched registers and the inputs, except debug_mode, which is registered.
- Reset (async): state=IDLE, debug_mode=0, latched pc/cause=0. Combinational outputs in IDLE with NONE: all 0.
- Defaults in every cycle unless overridden below: trap_target=0, ic_clean=0, trap_done=0, csr_write_enable=0, csr_trap_address=0, csr_trap_write_data=0.
- IDLE + ECALL/EBREAK/MISALIGNED:
  - Latch pc and cause (ECALL=11, EBREAK=3, MISALIGNED=0).
  - Next state WRITE_MEPC; outputs stay at defaults.
  - EBREAK additionally sets debug_mode=1 at this edge.
- WRITE_MEPC: csr_trap_address=341, csr_trap_write_data=latched pc, csr_write_enable=1. Next: WRITE_MCAUSE.
- WRITE_MCAUSE: csr_trap_address=342, csr_trap_write_data=latched cause (zero-extended), csr_write_enable=1. Next: READ_MTVEC.
- READ_MTVEC: csr_trap_address=305, csr_write_enable=0, trap_target={csr_read_data[31:2],2'b00} (direct mode), trap_done=1. Next: IDLE.
- Exception latency: 4 cycles from request to trap_done (IDLE, MEPC, MCAUSE, MTVEC).
- IDLE + MRET (single cycle, stays IDLE):
  - csr_trap_address=341, csr_write_enable=0.
  - trap_target=csr_read_data+4, mod 2^32 (wraps FFFF_FFFC -> 0000_0000).
  - trap_done=1; debug_mode cleared to 0 at the next edge.
- IDLE + FENCEI: ic_clean=1, trap_done=1 for that cycle; stays IDLE.
- Changes on trap_status or pc while state!=IDLE are ignored; the latched values are used.
- If trap_status still holds an exception code in the cycle after trap_done, a new sequence starts. The pipeline must clear or replace trap_status upon trap_done.
- Reset asserted mid-sequence: immediate return to IDLE, no further CSR writes, debug_mode=0.

Decomposition:
- Shared package/header (trap.vh): TRAP_* codes, CSR address constants (CSR_MTVEC/MEPC/MCAUSE) and mcause values.
- State encoding is local to the module. No sub-module needed; a single module suffices.

Test Plan:
- Reset 2 cycles, NONE -> state IDLE, all outputs 0.
- ECALL, pc=0000_1100, csr_read_data=1000_AA00 -> cycle 2: we=1, addr=341, wd=0000_1100; cycle 3: we=1, addr=342, wd=0000_000B; cycle 4: addr=305, trap_target=1000_AA00, trap_done=1; then IDLE.
- MRET, csr_read_data=0000_1100 -> same cycle: addr=341, we=0, trap_target=0000_1104, trap_done=1; debug_mode=0.
- MISALIGNED, pc=0000_1111, mtvec=1000_AA00 -> mepc write 0000_1111, mcause write 0, trap_target=1000_AA00. Then MRET with mepc=0000_1110 -> trap_target=0000_1114.
- EBREAK, pc=0000_BBB0 -> debug_mode=1 after first edge, mepc write 0000_BBB0, mcause write 3. Then MRET with 0000_BBB0 -> trap_target=0000_BBB4, debug_mode returns to 0.
- FENCEI -> ic_clean=1, trap_done=1 for one cycle. Assert rst during WRITE_MCAUSE -> IDLE immediately, csr_write_enable=0.

Source files
------------

// File: rtl/trap_controller_pkg.sv
// Shared trap codes, fixed CSR addresses and mcause values for the trap sequencer.
package trap_controller_pkg;

   localparam logic [2:0] TRAP_NONE       = 3'd0;
   localparam logic [2:0] TRAP_ECALL      = 3'd1;
   localparam logic [2:0] TRAP_EBREAK     = 3'd2;
   localparam logic [2:0] TRAP_MISALIGNED = 3'd3;
   localparam logic [2:0] TRAP_FENCEI     = 3'd4;
   localparam logic [2:0] TRAP_MRET       = 3'd5;

   localparam logic [11:0] CSR_MTVEC  = 12'h305;
   localparam logic [11:0] CSR_MEPC   = 12'h341;
   localparam logic [11:0] CSR_MCAUSE = 12'h342;

   localparam logic [3:0] MCAUSE_ECALL      = 4'd11;
   localparam logic [3:0] MCAUSE_EBREAK     = 4'd3;
   localparam logic [3:0] MCAUSE_MISALIGNED = 4'd0;

   // True for the codes that start the multi-cycle CSR sequence.
   function automatic logic is_exception(input logic [2:0] code);
      return (code == TRAP_ECALL) || (code == TRAP_EBREAK) || (code == TRAP_MISALIGNED);
   endfunction

   // mcause value for an exception code; non-exceptions map to 0.
   function automatic logic [3:0] cause_of(input logic [2:0] code);
      logic [3:0] cause;
      cause = MCAUSE_MISALIGNED;
      if (code == TRAP_ECALL) begin
         cause = MCAUSE_ECALL;
      end else if (code == TRAP_EBREAK) begin
         cause = MCAUSE_EBREAK;
      end
      return cause;
   endfunction

endpackage

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: writes mepc/mcause, reads mtvec, handles MRET and FENCE.I.
module trap_controller
   import trap_controller_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic [2:0]  trap_status,
   input  logic [31:0] csr_read_data,
   output logic [31:0] trap_target,
   output logic        ic_clean,
   output logic        debug_mode,
   output logic        trap_done,
   output logic        csr_write_enable,
   output logic [11:0] csr_trap_address,
   output logic [31:0] csr_trap_write_data
);

   typedef enum logic [1:0] {StIdle, StWriteMepc, StWriteMcause, StReadMtvec} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q;
   logic [3:0]  cause_q;
   logic        debug_q;
   logic        idle_exception;

   assign idle_exception = (state_q == StIdle) && is_exception(trap_status);
   assign debug_mode     = debug_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Latched trap context and debug flag; only sampled while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= '0;
         cause_q <= '0;
         debug_q <= 1'b0;
      end else if (state_q == StIdle) begin
         if (idle_exception) begin
            pc_q    <= pc;
            cause_q <= cause_of(trap_status);
         end
         if (trap_status == TRAP_EBREAK) begin
            debug_q <= 1'b1;
         end else if (trap_status == TRAP_MRET) begin
            debug_q <= 1'b0;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:        if (idle_exception) state_d = StWriteMepc;
         StWriteMepc:   state_d = StWriteMcause;
         StWriteMcause: state_d = StReadMtvec;
         StReadMtvec:   state_d = StIdle;
         default:       state_d = StIdle;
      endcase
   end

   // Output decode from state, latched context and live inputs.
   always_comb begin
      trap_target         = '0;
      ic_clean            = 1'b0;
      trap_done           = 1'b0;
      csr_write_enable    = 1'b0;
      csr_trap_address    = '0;
      csr_trap_write_data = '0;
      unique case (state_q)
         StIdle: begin
            if (trap_status == TRAP_MRET) begin
               csr_trap_address = CSR_MEPC;
               trap_target      = csr_read_data + 32'd4;
               trap_done        = 1'b1;
            end else if (trap_status == TRAP_FENCEI) begin
               ic_clean  = 1'b1;
               trap_done = 1'b1;
            end
         end
         StWriteMepc: begin
            csr_trap_address    = CSR_MEPC;
            csr_trap_write_data = pc_q;
            csr_write_enable    = 1'b1;
         end
         StWriteMcause: begin
            csr_trap_address    = CSR_MCAUSE;
            csr_trap_write_data = {28'd0, cause_q};
            csr_write_enable    = 1'b1;
         end
         StReadMtvec: begin
            csr_trap_address = CSR_MTVEC;
            // Direct mode only: the mode bits are dropped.
            trap_target      = {csr_read_data[31:2], 2'b00};
            trap_done        = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed plan followed by random transactions.
module tb_trap_controller;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic [2:0]  trap_status;
   logic [31:0] csr_read_data;
   logic [31:0] trap_target;
   logic        ic_clean;
   logic        debug_mode;
   logic        trap_done;
   logic        csr_write_enable;
   logic [11:0] csr_trap_address;
   logic [31:0] csr_trap_write_data;

   int checks;
   int errors;
   logic exp_debug;

   trap_controller dut (
      .clk                 (clk),
      .rst                 (rst),
      .pc                  (pc),
      .trap_status         (trap_status),
      .csr_read_data       (csr_read_data),
      .trap_target         (trap_target),
      .ic_clean            (ic_clean),
      .debug_mode          (debug_mode),
      .trap_done           (trap_done),
      .csr_write_enable    (csr_write_enable),
      .csr_trap_address    (csr_trap_address),
      .csr_trap_write_data (csr_trap_write_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Compare every output against one expected cycle.
   task automatic chk_all(input string tag, input logic [31:0] e_target, input logic e_ic,
                          input logic e_done, input logic e_we, input logic [11:0] e_addr,
                          input logic [31:0] e_wd);
      chk({tag, ".target"}, trap_target, e_target);
      chk({tag, ".ic_clean"}, {31'd0, ic_clean}, {31'd0, e_ic});
      chk({tag, ".debug"}, {31'd0, debug_mode}, {31'd0, exp_debug});
      chk({tag, ".done"}, {31'd0, trap_done}, {31'd0, e_done});
      chk({tag, ".we"}, {31'd0, csr_write_enable}, {31'd0, e_we});
      chk({tag, ".addr"}, {20'd0, csr_trap_address}, {20'd0, e_addr});
      chk({tag, ".wd"}, csr_trap_write_data, e_wd);
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mcause_for(input logic [2:0] code);
      if (code == 3'd1) return 32'd11;
      if (code == 3'd2) return 32'd3;
      return 32'd0;
   endfunction

   // Random code that must not be acted on while the sequencer is busy.
   function automatic logic [2:0] rnd_code();
      return 3'($urandom_range(0, 7));
   endfunction

   task automatic do_idle(input string tag);
      trap_status   = 3'($urandom_range(0, 2)) == 0 ? 3'd0 : 3'($urandom_range(6, 7));
      pc            = $urandom;
      csr_read_data = $urandom;
      @(negedge clk);
      chk_all(tag, 32'd0, 1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
      step();
   endtask

   task automatic do_exception(input string tag, input logic [2:0] code, input logic [31:0] p,
                               input logic [31:0] mtvec);
      trap_status   = code;
      pc            = p;
      csr_read_data = $urandom;
      @(negedge clk);
      chk_all({tag, ".req"}, 32'd0, 1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
      step();
      if (code == 3'd2) exp_debug = 1'b1;
      trap_status   = rnd_code();
      pc            = $urandom;
      csr_read_data = $urandom;
      @(negedge clk);
      chk_all({tag, ".mepc"}, 32'd0, 1'b0, 1'b0, 1'b1, 12'h341, p);
      step();
      trap_status   = rnd_code();
      pc            = $urandom;
      @(negedge clk);
      chk_all({tag, ".mcause"}, 32'd0, 1'b0, 1'b0, 1'b1, 12'h342, mcause_for(code));
      step();
      trap_status   = rnd_code();
      pc            = $urandom;
      csr_read_data = mtvec;
      @(negedge clk);
      chk_all({tag, ".mtvec"}, mtvec & 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 12'h305, 32'd0);
      step();
   endtask

   task automatic do_mret(input string tag, input logic [31:0] mepc);
      trap_status   = 3'd5;
      pc            = $urandom;
      csr_read_data = mepc;
      @(negedge clk);
      chk_all(tag, mepc + 32'd4, 1'b0, 1'b1, 1'b0, 12'h341, 32'd0);
      step();
      exp_debug = 1'b0;
   endtask

   task automatic do_fencei(input string tag);
      trap_status   = 3'd4;
      pc            = $urandom;
      csr_read_data = $urandom;
      @(negedge clk);
      chk_all(tag, 32'd0, 1'b1, 1'b1, 1'b0, 12'h000, 32'd0);
      step();
   endtask

   initial begin
      logic [2:0] code;
      checks        = 0;
      errors        = 0;
      exp_debug     = 1'b0;
      rst           = 1'b1;
      pc            = '0;
      trap_status   = 3'd0;
      csr_read_data = '0;

      // Reset for two cycles.
      @(negedge clk);
      chk_all("reset", 32'd0, 1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
      step();
      step();
      rst = 1'b0;
      do_idle("idle0");

      // Directed plan.
      do_exception("ecall", 3'd1, 32'h0000_1100, 32'h1000_AA00);
      do_idle("post_ecall");
      do_mret("mret0", 32'h0000_1100);
      do_exception("misal", 3'd3, 32'h0000_1111, 32'h1000_AA00);
      do_mret("mret1", 32'h0000_1110);
      do_exception("ebreak", 3'd2, 32'h0000_BBB0, 32'h1000_AA03);
      do_idle("post_ebreak");
      do_mret("mret2", 32'h0000_BBB0);
      do_idle("post_mret2");
      do_fencei("fencei");
      do_idle("post_fencei");
      do_mret("mret_wrap", 32'hFFFF_FFFC);

      // Exception still requested after trap_done restarts a sequence.
      do_exception("back2back_a", 3'd1, 32'h0000_2000, 32'h2000_0000);
      do_exception("back2back_b", 3'd1, 32'h0000_3000, 32'h3000_0000);

      // Reset during WRITE_MCAUSE of an EBREAK.
      trap_status = 3'd2;
      pc          = 32'h0000_4444;
      step();
      exp_debug   = 1'b1;
      trap_status = 3'd0;
      step();
      @(negedge clk);
      chk_all("rst_mid.mcause", 32'd0, 1'b0, 1'b0, 1'b1, 12'h342, 32'd3);
      #1 rst = 1'b1;
      #1 exp_debug = 1'b0;
      chk_all("rst_mid.async", 32'd0, 1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
      step();
      rst = 1'b0;
      do_idle("rst_mid.after");

      // Randomized transactions against the model.
      for (int i = 0; i < 200; i++) begin
         code = 3'($urandom_range(0, 7));
         case (code)
            3'd1, 3'd2, 3'd3: do_exception("rnd_exc", code, $urandom, $urandom);
            3'd4:             do_fencei("rnd_fencei");
            3'd5:             do_mret("rnd_mret", $urandom);
            default:          do_idle("rnd_idle");
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
